// File: rtl/wb_byte_loader_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the byte-stream Wishbone loader.
package wb_byte_loader_pkg;

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] OpHold  = 8'h48;
  localparam logic [7:0] OpGo    = 8'h47;

  localparam logic [7:0] RespOk  = 8'h4B;
  localparam logic [7:0] RespErr = 8'h45;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StData = 3'd2,
    StBus  = 3'd3,
    StResp = 3'd4
  } state_e;

endpackage

// File: rtl/wb_byte_loader_if.sv
// Classic single-cycle Wishbone bus between the loader (master) and the backdoor port (slave).
interface wb_byte_loader_if;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_strobe_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  modport master (
    output wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_strobe_o,
    input  wb_data_i, wb_ack_i
  );

  modport slave (
    input  wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_strobe_o,
    output wb_data_i, wb_ack_i
  );
endinterface

// File: rtl/wb_byte_loader_tx_shift.sv
// Response shifter: holds up to four bytes, presents them MSB-first, and flags the last accept.
module wb_byte_loader_tx_shift (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic [2:0]  load_count,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [31:0] word_q;
  logic [2:0]  cnt_q;
  logic        valid_q;
  logic        accept;

  assign accept = valid_q & tx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= load_word;
      cnt_q   <= load_count;
      valid_q <= (load_count != 3'd0);
    end else if (accept) begin
      word_q <= {word_q[23:0], 8'h00};
      cnt_q  <= cnt_q - 3'd1;
      if (cnt_q == 3'd1) valid_q <= 1'b0;
    end
  end

  assign tx_data  = word_q[31:24];
  assign tx_valid = valid_q;
  assign done     = accept && (cnt_q == 3'd1);

endmodule

// File: rtl/wb_byte_loader.sv
// Framed byte commands in, single Wishbone cycles out; also gates the CPU reset during loading.
module wb_byte_loader
  import wb_byte_loader_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  wb_byte_loader_if.master         wb,
  output logic                     cpu_reset_o
);

  state_e      state_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        cyc_q;
  logic        bus_we_q;
  logic        cpu_reset_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] to_cnt_q;

  logic        timeout;
  logic        tx_load;
  logic [31:0] tx_word;
  logic [2:0]  tx_count;
  logic        tx_done;

  assign timeout = (to_cnt_q == ACK_TIMEOUT - 1);

  // Response is loaded on the same edge the FSM enters StResp, so the first byte is valid next cycle.
  always_comb begin
    tx_load  = 1'b0;
    tx_word  = '0;
    tx_count = 3'd1;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == OpHold || rx_data == OpGo)) begin
          tx_load = 1'b1;
          tx_word = {RespOk, 24'h0};
        end
      end
      StBus: begin
        if (wb.wb_ack_i) begin
          tx_load = 1'b1;
          if (we_q) begin
            tx_word = {RespOk, 24'h0};
          end else begin
            tx_word  = wb.wb_data_i;
            tx_count = 3'd4;
          end
        end else if (timeout) begin
          tx_load = 1'b1;
          tx_word = {RespErr, 24'h0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cyc_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      cpu_reset_q <= HOLD_ON_RESET;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            case (rx_data)
              OpWrite, OpRead: begin
                we_q       <= (rx_data == OpWrite);
                byte_cnt_q <= '0;
                state_q    <= StAddr;
              end
              OpHold: begin
                cpu_reset_q <= 1'b1;
                state_q     <= StResp;
              end
              OpGo: begin
                cpu_reset_q <= 1'b0;
                state_q     <= StResp;
              end
              default: ;
            endcase
          end
        end
        StAddr: begin
          if (rx_valid) begin
            addr_q     <= {addr_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (we_q) begin
                state_q <= StData;
              end else begin
                state_q  <= StBus;
                cyc_q    <= 1'b1;
                bus_we_q <= 1'b0;
              end
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            data_q     <= {data_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q  <= StBus;
              cyc_q    <= 1'b1;
              bus_we_q <= 1'b1;
            end
          end
        end
        StBus: begin
          if (wb.wb_ack_i || timeout) begin
            cyc_q    <= 1'b0;
            bus_we_q <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= StResp;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        StResp: begin
          if (tx_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  wb_byte_loader_tx_shift u_tx_shift (
    .clock      (clock),
    .reset      (reset),
    .load       (tx_load),
    .load_word  (tx_word),
    .load_count (tx_count),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .done       (tx_done)
  );

  assign wb.wb_addr_o   = addr_q;
  assign wb.wb_data_o   = data_q;
  assign wb.wb_we_o     = bus_we_q;
  assign wb.wb_cyc_o    = cyc_q;
  assign wb.wb_strobe_o = cyc_q;
  assign cpu_reset_o    = cpu_reset_q;

endmodule

// File: tb/tb_wb_byte_loader.sv
// Directed bench for wb_byte_loader: CPU hold/go, write, read, timeout, tx stall, reset in BUS.
module tb_wb_byte_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       cpu_reset_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_byte_loader_if bus ();

  wb_byte_loader #(
    .ACK_TIMEOUT   (255),
    .HOLD_ON_RESET (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .wb          (bus.master),
    .cpu_reset_o (cpu_reset_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is consumed by the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Wait (bounded) for a tx byte, compare it, and let it be accepted (tx_ready assumed high).
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    check(tag, {24'd0, tx_data}, {24'd0, exp});
    @(negedge clock);
  endtask

  initial begin
    int   n;
    logic seen;

    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    bus.wb_ack_i  = 1'b0;
    bus.wb_data_i = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    check("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_addr", bus.wb_addr_o, 32'h0);

    // Go, then hold.
    send_byte(8'h47);
    check("go_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
    expect_tx("go_resp", 8'h4B);
    check("go_tx_idle", {31'd0, tx_valid}, 32'd0);
    send_byte(8'h48);
    check("hold_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    expect_tx("hold_resp", 8'h4B);

    // Write 0x0000000A to 0x00000004, ack on the second BUS cycle.
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("wr_cyc_before_last", {31'd0, bus.wb_cyc_o}, 32'd0);
    send_byte(8'h0A);
    check("wr_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    check("wr_stb", {31'd0, bus.wb_strobe_o}, 32'd1);
    check("wr_we", {31'd0, bus.wb_we_o}, 32'd1);
    check("wr_addr", bus.wb_addr_o, 32'h0000_0004);
    check("wr_data", bus.wb_data_o, 32'h0000_000A);
    @(negedge clock);
    check("wr_cyc_held", {31'd0, bus.wb_cyc_o}, 32'd1);
    bus.wb_ack_i = 1'b1;
    @(negedge clock);
    bus.wb_ack_i = 1'b0;
    check("wr_cyc_drop", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("wr_we_drop", {31'd0, bus.wb_we_o}, 32'd0);
    check("wr_resp_latency", {31'd0, tx_valid}, 32'd1);
    expect_tx("wr_resp", 8'h4B);

    // Read 0x00010000 returning 0xDEADBEEF.
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    check("rd_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    check("rd_we", {31'd0, bus.wb_we_o}, 32'd0);
    check("rd_addr", bus.wb_addr_o, 32'h0001_0000);
    bus.wb_ack_i  = 1'b1;
    bus.wb_data_i = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.wb_ack_i  = 1'b0;
    bus.wb_data_i = 32'h0;
    expect_tx("rd_b0", 8'hDE);
    expect_tx("rd_b1", 8'hAD);
    expect_tx("rd_b2", 8'hBE);
    expect_tx("rd_b3", 8'hEF);
    check("rd_tx_idle", {31'd0, tx_valid}, 32'd0);

    // Read of an unmapped address: no ack, abort after 255 cycles.
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    n = 0;
    while (bus.wb_cyc_o && n < 400) begin
      n++;
      @(negedge clock);
    end
    check("to_cyc_cycles", n, 32'd255);
    check("to_stb_drop", {31'd0, bus.wb_strobe_o}, 32'd0);
    expect_tx("to_resp", 8'h45);
    check("to_tx_idle", {31'd0, tx_valid}, 32'd0);

    // Read after timeout, with the sink stalling after the first byte.
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    check("st_addr", bus.wb_addr_o, 32'h0000_0008);
    bus.wb_ack_i  = 1'b1;
    bus.wb_data_i = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.wb_ack_i  = 1'b0;
    bus.wb_data_i = 32'h0;
    expect_tx("st_b0", 8'hDE);
    tx_ready = 1'b0;
    send_byte(8'h47);
    for (int i = 0; i < 9; i++) begin
      check("st_hold_data", {24'd0, tx_data}, 32'h0000_00AD);
      check("st_hold_valid", {31'd0, tx_valid}, 32'd1);
      @(negedge clock);
    end
    check("st_rx_ignored", {31'd0, cpu_reset_o}, 32'd1);
    tx_ready = 1'b1;
    expect_tx("st_b1", 8'hAD);
    expect_tx("st_b2", 8'hBE);
    expect_tx("st_b3", 8'hEF);
    check("st_tx_idle", {31'd0, tx_valid}, 32'd0);

    // Reset while in BUS: cycle dropped, no response.
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    check("rb_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rb_cyc_drop", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("rb_stb_drop", {31'd0, bus.wb_strobe_o}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (tx_valid) seen = 1'b1;
    end
    check("rb_no_tx", {31'd0, seen}, 32'd0);

    // Unknown opcode: nothing happens, then the loader still decodes commands.
    send_byte(8'h00);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tx_valid || bus.wb_cyc_o) seen = 1'b1;
      @(negedge clock);
    end
    check("bad_op_quiet", {31'd0, seen}, 32'd0);
    send_byte(8'h47);
    check("final_go_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
    expect_tx("final_go_resp", 8'h4B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
